// File: rtl/interlock_card.sv
// Safety interlock card: synchronised and filtered alarm inputs, sticky alarm
// latches with first-fault capture, and an IDLE/ARMING/READY/TRIP supply FSM.
module interlock_card #(
  parameter int N_ALARM     = 8,
  parameter int FILT_LEN    = 4,
  parameter int HOLD_CYCLES = 128,
  parameter int IW          = $clog2(N_ALARM)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_ALARM-1:0] alarm_in,
  input  logic               ps_req,
  input  logic               permit_in,
  input  logic               ack,
  output logic               o_not_alarm,
  output logic               o_not_on_perm,
  output logic               o_ready,
  output logic               o_trip,
  output logic [N_ALARM-1:0] o_latched,
  output logic [IW-1:0]      o_first_idx,
  output logic               o_first_vld,
  output logic [7:0]         o_trip_cnt
);

  localparam int CW = 8;
  localparam int HW = 16;

  typedef enum logic [1:0] {IDLE, ARMING, READY, TRIP} state_t;

  logic [N_ALARM-1:0] alarm_meta, alarm_sync;
  logic               ps_meta, ps_sync, permit_meta, permit_sync;

  // NOTE: every clocked register uses non-blocking (<=) so all flops sample
  // the pre-edge values; blocking here would collapse the two sync stages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_meta  <= '0;
      alarm_sync  <= '0;
      ps_meta     <= 1'b0;
      ps_sync     <= 1'b0;
      permit_meta <= 1'b0;
      permit_sync <= 1'b0;
    end else begin
      alarm_meta  <= alarm_in;
      alarm_sync  <= alarm_meta;
      ps_meta     <= ps_req;
      ps_sync     <= ps_meta;
      permit_meta <= permit_in;
      permit_sync <= permit_meta;
    end
  end

  logic [N_ALARM-1:0] filt;

  for (genvar g = 0; g < N_ALARM; g++) begin : g_filt
    logic [CW-1:0] cnt;
    logic          bit_q;

    // NOTE: the per-bit counters form a register array that is still cleared
    // on reset, since a stale count would shorten the first filter window.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt   <= '0;
        bit_q <= 1'b0;
      end else if (alarm_sync[g] != bit_q) begin
        if (cnt == CW'(FILT_LEN - 1)) begin
          bit_q <= alarm_sync[g];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end

    assign filt[g] = bit_q;
  end

  logic [N_ALARM-1:0] latched_next;
  logic [IW-1:0]      low_idx;

  // NOTE: low_idx gets its default before the loop so no latch is inferred.
  always_comb begin
    low_idx = '0;
    for (int i = N_ALARM - 1; i >= 0; i--) begin
      if (filt[i]) low_idx = IW'(i);
    end
  end

  // Ack keeps exactly the bits whose alarm is still present.
  assign latched_next = ack ? filt : (o_latched | filt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_not_alarm <= 1'b1;
      o_latched   <= '0;
      o_first_idx <= '0;
      o_first_vld <= 1'b0;
    end else begin
      o_not_alarm <= ~|filt;
      o_latched   <= latched_next;
      if (o_latched == '0 && filt != '0) begin
        o_first_idx <= low_idx;
        o_first_vld <= 1'b1;
      end else if (ack && latched_next == '0) begin
        o_first_idx <= '0;
        o_first_vld <= 1'b0;
      end
    end
  end

  state_t        state, state_next;
  logic [HW-1:0] hold, hold_next;

  always_comb begin
    state_next = state;
    hold_next  = hold;
    unique case (state)
      IDLE: begin
        if (ps_sync && o_not_alarm && o_latched == '0) begin
          state_next = ARMING;
          hold_next  = '0;
        end
      end
      ARMING: begin
        if (!o_not_alarm)                       state_next = TRIP;
        else if (!ps_sync)                      state_next = IDLE;
        else if (hold == HW'(HOLD_CYCLES - 1))  state_next = READY;
        else                                    hold_next  = hold + 1'b1;
      end
      READY: begin
        if (!o_not_alarm)  state_next = TRIP;
        else if (!ps_sync) state_next = IDLE;
      end
      TRIP: begin
        if (ack && !ps_sync && filt == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      hold       <= '0;
      o_trip_cnt <= '0;
    end else begin
      state <= state_next;
      hold  <= hold_next;
      if (state_next == TRIP && state != TRIP && o_trip_cnt != 8'hFF)
        o_trip_cnt <= o_trip_cnt + 1'b1;
    end
  end

  assign o_not_on_perm = ~(o_not_alarm & permit_sync);
  assign o_ready       = (state == READY);
  assign o_trip        = (state == TRIP);

endmodule

// File: tb/tb_interlock_card.sv
// Self-checking bench for interlock_card: directed scenarios plus randomized
// traffic compared every cycle against a behavioural model.
module tb_interlock_card;

  localparam int N    = 8;
  localparam int FILT = 4;
  localparam int HOLD = 128;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] alarm_in;
  logic         ps_req, permit_in, ack;
  logic         o_not_alarm, o_not_on_perm, o_ready, o_trip, o_first_vld;
  logic [N-1:0] o_latched;
  logic [2:0]   o_first_idx;
  logic [7:0]   o_trip_cnt;

  int n_total = 0;
  int n_bad   = 0;

  interlock_card #(.N_ALARM(N), .FILT_LEN(FILT), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .alarm_in(alarm_in), .ps_req(ps_req),
    .permit_in(permit_in), .ack(ack), .o_not_alarm(o_not_alarm),
    .o_not_on_perm(o_not_on_perm), .o_ready(o_ready), .o_trip(o_trip),
    .o_latched(o_latched), .o_first_idx(o_first_idx),
    .o_first_vld(o_first_vld), .o_trip_cnt(o_trip_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: input history, run-length filters, named modes.
  bit [N-1:0] m_a1, m_a2;
  bit         m_ps1, m_ps2, m_pm1, m_pm2;
  int         m_run [N];
  bit [N-1:0] m_flt, m_lat;
  bit         m_na, m_fvld;
  int         m_fidx, m_armed, m_trips;
  string      m_mode;

  task automatic model_reset();
    m_a1 = '0; m_a2 = '0;
    m_ps1 = 0; m_ps2 = 0; m_pm1 = 0; m_pm2 = 0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
    m_flt = '0; m_lat = '0; m_na = 1; m_fvld = 0;
    m_fidx = 0; m_armed = 0; m_trips = 0;
    m_mode = "idle";
  endtask

  task automatic model_step();
    bit [N-1:0] f0, l0;
    bit         na0, found;
    string      nm;
    f0 = m_flt; l0 = m_lat; na0 = m_na; nm = m_mode;
    for (int i = 0; i < N; i++) begin
      if (m_a2[i] != f0[i]) begin
        if (m_run[i] + 1 >= FILT) begin
          m_flt[i] = m_a2[i];
          m_run[i] = 0;
        end else m_run[i]++;
      end else m_run[i] = 0;
    end
    m_na  = (f0 == 0);
    m_lat = ack ? f0 : (l0 | f0);
    if (l0 == 0 && f0 != 0) begin
      found = 0;
      for (int i = 0; i < N; i++)
        if (f0[i] && !found) begin m_fidx = i; found = 1; end
      m_fvld = 1;
    end else if (ack && m_lat == 0) begin
      m_fidx = 0; m_fvld = 0;
    end
    if (m_mode == "idle") begin
      if (m_ps2 && na0 && l0 == 0) begin nm = "arming"; m_armed = 0; end
    end else if (m_mode == "arming") begin
      if (!na0) nm = "trip";
      else if (!m_ps2) nm = "idle";
      else if (m_armed == HOLD - 1) nm = "ready";
      else m_armed++;
    end else if (m_mode == "ready") begin
      if (!na0) nm = "trip";
      else if (!m_ps2) nm = "idle";
    end else if (m_mode == "trip") begin
      if (ack && !m_ps2 && f0 == 0) nm = "idle";
    end
    if (nm == "trip" && m_mode != "trip" && m_trips < 255) m_trips++;
    m_mode = nm;
    m_a2 = m_a1; m_a1 = alarm_in;
    m_ps2 = m_ps1; m_ps1 = ps_req;
    m_pm2 = m_pm1; m_pm1 = permit_in;
  endtask

  function automatic logic [31:0] dut_word();
    return 32'({o_not_alarm, o_not_on_perm, o_ready, o_trip, o_latched,
                o_first_idx, o_first_vld, o_trip_cnt});
  endfunction

  function automatic logic [31:0] model_word();
    logic [2:0] idx;
    logic [7:0] tc;
    idx = 3'(m_fidx);
    tc  = 8'(m_trips);
    return 32'({m_na, ~(m_na & m_pm2), m_mode == "ready", m_mode == "trip",
                m_lat, idx, m_fvld, tc});
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset();
    else        model_step();
    #1;
    check("cycle", dut_word(), model_word());
  endtask

  task automatic pulse_ack();
    ack = 1'b1; tick();
    ack = 1'b0; tick();
  endtask

  // Counts edges from ps_req rising to o_ready; -1 if the bound expires.
  task automatic measure_ready(output int lat, output int nop_high);
    lat = -1; nop_high = 0;
    ps_req = 1'b1;
    for (int c = 1; c <= 200 && lat < 0; c++) begin
      tick();
      if (o_ready) lat = c;
      else if (c > 2 && o_not_on_perm) nop_high++;
    end
  endtask

  int lat, nop_high;
  // Reset state word: not_alarm=1, not_on_perm=1, everything else 0.
  localparam logic [31:0] RST_WORD = 32'h00C0_0000;

  initial begin
    reset = 1'b0; alarm_in = '0; ps_req = 1'b0; permit_in = 1'b1; ack = 1'b0;
    model_reset();
    tick(); tick();
    check("reset_outputs", dut_word(), RST_WORD);
    reset = 1'b1;
    repeat (4) tick();
    check("idle_perm_ok", {o_not_on_perm, o_ready, o_trip}, 3'b000);

    // Two synchroniser edges, one edge into ARMING, then the full hold.
    measure_ready(lat, nop_high);
    check("ready_latency", lat, 2 + 1 + HOLD);
    check("nop_during_arm", nop_high, 0);

    // A 3-cycle glitch is shorter than the filter window.
    alarm_in[5] = 1'b1; repeat (3) tick();
    alarm_in[5] = 1'b0; repeat (10) tick();
    check("glitch_state", {o_not_alarm, o_ready, o_latched}, {2'b11, 8'h00});

    alarm_in[5] = 1'b1; repeat (10) tick();
    check("trip5_trip", o_trip, 1);
    check("trip5_latched", o_latched, 8'h20);
    check("trip5_first", {o_first_vld, o_first_idx}, {1'b1, 3'd5});
    check("trip5_count", o_trip_cnt, 8'd1);

    alarm_in = '0; ps_req = 1'b0; repeat (10) tick();
    pulse_ack();
    check("clear_state", {o_ready, o_trip, o_latched, o_first_vld}, 11'd0);

    ps_req = 1'b1; repeat (5) tick();
    alarm_in = 8'h44; repeat (10) tick();
    check("two_rise_idx", {o_first_vld, o_first_idx}, {1'b1, 3'd2});
    alarm_in[1] = 1'b1; repeat (10) tick();
    check("later_no_overwrite", {o_first_idx, o_latched}, {3'd2, 8'h46});
    alarm_in = 8'h40; repeat (10) tick();
    pulse_ack();
    check("ack_partial_latched", o_latched, 8'h40);
    check("ack_partial_first", {o_first_vld, o_first_idx, o_trip}, {1'b1, 3'd2, 1'b1});

    alarm_in = '0; ps_req = 1'b0; repeat (10) tick();
    pulse_ack();
    check("trip_exit", {o_trip, o_latched, o_first_vld}, 10'd0);
    check("trip_count_two", o_trip_cnt, 8'd2);

    for (int t = 0; t < 256; t++) begin
      ps_req = 1'b1; repeat (4) tick();
      alarm_in[0] = 1'b1; repeat (10) tick();
      alarm_in[0] = 1'b0; ps_req = 1'b0; repeat (10) tick();
      pulse_ack();
    end
    check("trip_count_saturated", o_trip_cnt, 8'd255);

    // Reset pulse at ARMING count 100, then a fresh full hold is needed.
    ps_req = 1'b1; repeat (3 + 100) tick();
    check("arming_before_reset", {o_ready, o_trip}, 2'b00);
    reset = 1'b0; model_reset(); #1;
    check("async_reset_outputs", dut_word(), RST_WORD);
    tick();
    reset = 1'b1;
    ps_req = 1'b0;
    measure_ready(lat, nop_high);
    check("ready_after_reset", lat, 2 + 1 + HOLD);

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 9) == 0) alarm_in[$urandom_range(0, N - 1)] ^= 1'b1;
      if ($urandom_range(0, 39) == 0) ps_req = ~ps_req;
      if ($urandom_range(0, 29) == 0) permit_in = ~permit_in;
      ack = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 799) == 0) begin
        reset = 1'b0; model_reset(); #1;
        check("rand_async_reset", dut_word(), RST_WORD);
        tick();
        reset = 1'b1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
